peripheral_arbiter: RTL and testbench

- Round-robin arbiter that shares the single-port memory-mapped peripherals register bank between two requesters: requester 0 is the CPU load/store unit, requester 1 is the debug/monitor port.
- Latches one request at a time, drives the bank's address/input_data/should_write for exactly one access cycle, captures read data and returns it with a one-cycle ack pulse.
- Rejects addresses outside the peripheral window with an error response and no side effects.

---
 rtl/peripheral_arbiter.sv | 136 +++++++++++++
 tb/tb_peripheral_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_arbiter.sv
// Purpose : round-robin arbiter sharing the single-port peripheral register bank between the CPU LSU (req0) and the debug port (req1).
// Latency : ack pulses 2 cycles after the req-sampling edge; a new grant is possible at most every 3 cycles.
// Backpress: requesters hold req until ack; a request is latched at grant, so a later req/addr/wdata change does not affect it.
//
// Ports:
//   clock, reset                    system clock, synchronous active-high reset
//   reqN/addrN/wdataN/weN           requester N command (N = 0 CPU, 1 debug)
//   ackN/errN                       one-cycle completion pulse; err = address outside the window
//   rdata                           read data, valid only in the ack cycle
//   p_address/p_input_data/
//   p_should_write/p_output_data    bank access port (bank writes on the mid-cycle negedge)
//   busy                            high whenever a transaction is in flight
module peripheral_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WINDOW_BITS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  output logic        ack1,
  output logic        err1,
  output logic [31:0] rdata,
  output logic [31:0] p_address,
  output logic [31:0] p_input_data,
  output logic        p_should_write,
  input  logic [31:0] p_output_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        lat_we;
  logic        lat_id;
  logic        lat_in_window;

  logic        grant_vld;
  logic        grant_id;
  logic        grant_tie;
  logic [31:0] grant_addr;
  logic [31:0] grant_wdata;
  logic        grant_we;
  logic        grant_in_window;

  always_comb begin
    state_next      = state;
    grant_vld       = 1'b0;
    grant_id        = 1'b0;
    grant_tie       = 1'b0;
    ack0            = 1'b0;
    ack1            = 1'b0;
    err0            = 1'b0;
    err1            = 1'b0;
    p_should_write  = 1'b0;
    busy            = (state != IDLE);

    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_vld = 1'b1;
          grant_tie = 1'b1;
          grant_id  = ~last_grant;
        end else if (req0) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (req1) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        if (grant_vld) state_next = ACCESS;
      end
      ACCESS: begin
        // Gated by reset so an abandoned write is withdrawn within the reset cycle itself.
        p_should_write = lat_we && lat_in_window && !reset;
        state_next     = RESPOND;
      end
      RESPOND: begin
        ack0       = ~lat_id;
        ack1       = lat_id;
        err0       = ~lat_id & ~lat_in_window;
        err1       = lat_id & ~lat_in_window;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_addr      = grant_id ? addr1  : addr0;
  assign grant_wdata     = grant_id ? wdata1 : wdata0;
  assign grant_we        = grant_id ? we1    : we0;
  assign grant_in_window = (grant_addr[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);

  // p_address / p_input_data double as the latched request: they load at grant
  // and then hold, so the bank sees the latched values throughout ACCESS.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      lat_we        <= 1'b0;
      lat_id        <= 1'b0;
      lat_in_window <= 1'b0;
      rdata         <= 32'd0;
      p_address     <= 32'd0;
      p_input_data  <= 32'd0;
    end else begin
      state <= state_next;
      if (grant_vld) begin
        p_address     <= grant_addr;
        p_input_data  <= grant_wdata;
        lat_we        <= grant_we;
        lat_id        <= grant_id;
        lat_in_window <= grant_in_window;
        if (grant_tie) last_grant <= grant_id;
      end
      if (state == ACCESS) begin
        rdata <= (lat_in_window && !lat_we) ? p_output_data : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter.sv
module tb_peripheral_arbiter;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, err0, ack1, err1, p_should_write, busy;
  logic [31:0] rdata, p_address, p_input_data, p_output_data;

  always #5 clock = ~clock;

  peripheral_arbiter #(.BASE_ADDR(BASE), .WINDOW_BITS(3)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1), .err1(err1),
    .rdata(rdata), .p_address(p_address), .p_input_data(p_input_data),
    .p_should_write(p_should_write), .p_output_data(p_output_data), .busy(busy)
  );

  // Bank model: entries 0..3 are 1-bit flag registers holding input_data[31];
  // entries 4..7 are read-only status words that ignore writes.
  logic [31:0] rw_mem [0:3];

  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rw_mem[i] <= 32'd0;
    end else if (p_should_write && p_address[2:0] < 3'd4) begin
      rw_mem[p_address[1:0]] <= {31'd0, p_input_data[31]};
    end
  end

  always_comb begin
    p_output_data = 32'd0;
    case (p_address[2:0])
      3'd4:    p_output_data = 32'd1;
      3'd5:    p_output_data = 32'h0000_00A5;
      3'd6:    p_output_data = 32'h0000_0066;
      3'd7:    p_output_data = 32'hDEAD_0007;
      default: p_output_data = rw_mem[p_address[1:0]];
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  int   wr_count = 0;
  logic [31:0] wr_addr = '0, wr_data = '0;

  // Output monitor: bank write pulses, ack/err invariants and scoreboard pops.
  always @(negedge clock) begin
    if (mon_en) begin
      if (p_should_write) begin
        wr_count++;
        wr_addr = p_address;
        wr_data = p_input_data;
      end
      chk("dual_ack", 32'(ack0 & ack1), 32'd0);
      chk("err_without_ack", 32'((err0 & ~ack0) | (err1 & ~ack1)), 32'd0);
      if (ack0 || ack1) begin
        chk("ack_while_busy", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'({ack1, ack0}), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_id", 32'({ack1, ack0}), mon_e.id ? 32'd2 : 32'd1);
          chk("ack_err", 32'(mon_e.id ? err1 : err0), 32'(mon_e.err));
          chk("ack_rdata", rdata, mon_e.rdata);
        end
      end
    end
  end

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_wr;
  } vec_t;

  // Entered and left at posedge+2. Scrambles addr/wdata right after the grant edge
  // so the expected results only hold if the request was latched.
  task automatic run_txn(input vec_t v);
    int n;
    int wr0;
    bit got;
    wr0 = wr_count;
    if (v.id == 1'b0) begin
      req0 = 1'b1; addr0 = v.addr; wdata0 = v.wdata; we0 = v.we;
    end else begin
      req1 = 1'b1; addr1 = v.addr; wdata1 = v.wdata; we1 = v.we;
    end
    sb.push_back('{id: v.id, err: v.exp_err, rdata: v.exp_rdata});
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clock);
      n++;
      #2;
      if (n == 1) begin
        addr0 = ~v.addr; wdata0 = ~v.wdata;
        addr1 = ~v.addr; wdata1 = ~v.wdata;
      end
      @(negedge clock);
      if ((v.id == 1'b0 && ack0) || (v.id == 1'b1 && ack1)) begin
        got = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(n), 32'd2);
    @(posedge clock);
    #2;
    chk("wr_pulses", 32'(wr_count - wr0), 32'(v.exp_wr));
    if (v.exp_wr != 0) begin
      chk("wr_addr", wr_addr, v.addr);
      chk("wr_data", wr_data, v.wdata);
    end
    chk("busy_after_txn", 32'(busy), 32'd0);
  endtask

  vec_t vt[14];

  initial begin
    vt[0]  = '{1'b0, BASE + 32'd4, 32'd0,          1'b0, 1'b0, 32'd1,          0};
    vt[1]  = '{1'b1, BASE + 32'd2, 32'h8000_0000,  1'b1, 1'b0, 32'd0,          1};
    vt[2]  = '{1'b0, BASE + 32'd2, 32'd0,          1'b0, 1'b0, 32'd1,          0};
    vt[3]  = '{1'b0, 32'h0000_2000, 32'h8000_0000, 1'b1, 1'b1, 32'd0,          0};
    vt[4]  = '{1'b1, BASE - 32'd4, 32'd0,          1'b0, 1'b1, 32'd0,          0};
    vt[5]  = '{1'b1, BASE + 32'd8, 32'd0,          1'b0, 1'b1, 32'd0,          0};
    vt[6]  = '{1'b0, BASE + 32'd5, 32'h8000_0000,  1'b1, 1'b0, 32'd0,          1};
    vt[7]  = '{1'b1, BASE + 32'd5, 32'd0,          1'b0, 1'b0, 32'h0000_00A5, 0};
    vt[8]  = '{1'b0, BASE + 32'd1, 32'h8000_0000,  1'b1, 1'b0, 32'd0,          1};
    vt[9]  = '{1'b1, BASE + 32'd1, 32'd0,          1'b0, 1'b0, 32'd1,          0};
    vt[10] = '{1'b1, BASE + 32'd1, 32'h7FFF_FFFF,  1'b1, 1'b0, 32'd0,          1};
    vt[11] = '{1'b0, BASE + 32'd1, 32'd0,          1'b0, 1'b0, 32'd0,          0};
    vt[12] = '{1'b1, BASE + 32'd7, 32'd0,          1'b0, 1'b0, 32'hDEAD_0007, 0};
    vt[13] = '{1'b0, 32'h0000_2004, 32'd0,         1'b0, 1'b1, 32'd0,          0};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_err", 32'({err1, err0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pwrite", 32'(p_should_write), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_paddr", p_address, 32'd0);
    chk("rst_pdata", p_input_data, 32'd0);
    mon_en = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;

    for (int i = 0; i < 14; i++) run_txn(vt[i]);

    // Contention from a fresh reset: 0,1,0,1 with one ack every 3 cycles.
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    req0 = 1'b1; addr0 = BASE + 32'd4; we0 = 1'b0;
    req1 = 1'b1; addr1 = BASE + 32'd7; we1 = 1'b0;
    for (int k = 0; k < 4; k++)
      sb.push_back('{id: k[0], err: 1'b0, rdata: k[0] ? 32'hDEAD_0007 : 32'd1});
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("cont_ack0", 32'(ack0), 32'(c == 2 || c == 8));
      chk("cont_ack1", 32'(ack1), 32'(c == 5 || c == 11));
      if (c == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(posedge clock);
    #2;
    chk("cont_sb_empty", 32'(sb.size()), 32'd0);
    chk("cont_busy", 32'(busy), 32'd0);

    // Request withdrawn after one cycle still completes.
    req1 = 1'b1; addr1 = BASE + 32'd4; we1 = 1'b0;
    sb.push_back('{id: 1'b1, err: 1'b0, rdata: 32'd1});
    @(posedge clock);
    #2;
    req1 = 1'b0;
    @(negedge clock);
    chk("wd_busy_access", 32'(busy), 32'd1);
    @(posedge clock);
    @(negedge clock);
    chk("wd_ack1", 32'(ack1), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("wd_idle_busy", 32'(busy), 32'd0);
      chk("wd_idle_ack1", 32'(ack1), 32'd0);
    end
    @(posedge clock);
    #2;

    // Reset during ACCESS of an in-window write.
    begin
      int wr0;
      wr0 = wr_count;
      req0 = 1'b1; addr0 = BASE + 32'd3; wdata0 = 32'h8000_0000; we0 = 1'b1;
      @(posedge clock);
      #2;
      reset = 1'b1;
      req0 = 1'b0;
      @(negedge clock);
      chk("rmid_pwrite_drop", 32'(p_should_write), 32'd0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      @(negedge clock);
      chk("rmid_ack", 32'({ack1, ack0}), 32'd0);
      chk("rmid_err", 32'({err1, err0}), 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_pwrite", 32'(p_should_write), 32'd0);
      chk("rmid_rdata", rdata, 32'd0);
      chk("rmid_paddr", p_address, 32'd0);
      chk("rmid_pdata", p_input_data, 32'd0);
      chk("rmid_no_write", 32'(wr_count - wr0), 32'd0);
    end
    repeat (3) @(negedge clock);
    @(posedge clock);
    #2;
    req0 = 1'b1; addr0 = BASE + 32'd4; we0 = 1'b0;
    req1 = 1'b1; addr1 = BASE + 32'd7; we1 = 1'b0;
    sb.push_back('{id: 1'b0, err: 1'b0, rdata: 32'd1});
    @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("rmid_first_ack0", 32'(ack0), 32'd1);
    chk("rmid_first_ack1", 32'(ack1), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
